// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the pd3 mux-select arbiter.
// State encoding, requester count and default hold limit.
package mux_sel_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master = requesting side, slave = arbiter side.
interface mux_sel_arbiter_if;

  logic [3:0] w_req_4;
  logic [3:0] w_done_4;
  logic [3:0] w_grant_4;
  logic [1:0] w_sel_2;
  logic       w_busy_1;
  logic       w_timeout_1;

  modport master (
    output w_req_4,
    output w_done_4,
    input  w_grant_4,
    input  w_sel_2,
    input  w_busy_1,
    input  w_timeout_1
  );

  modport slave (
    input  w_req_4,
    input  w_done_4,
    output w_grant_4,
    output w_sel_2,
    output w_busy_1,
    output w_timeout_1
  );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick_4.sv
// Rotating-priority picker: first set request after ptr.
// Search order ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick_4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  // Walk from lowest priority up so the highest priority wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = 2'd0;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared pd3 4:1 mux and its port.
// Optional hold watchdog: define MUX_ARB_WATCHDOG_EN.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  mux_sel_arbiter_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 ||
      (2 ** CNT_W) <= MAX_HOLD) begin : g_bad
    $error("mux_sel_arbiter: bad MAX_HOLD/CNT_W");
  end

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [1:0] idx;
  logic       own_rel;
  logic       wd_rel;

  rr_pick_4 u_pick (
    .req_i   (bus.w_req_4),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (idx)
  );

  assign own_rel = bus.w_done_4[sel_q] |
                   ~bus.w_req_4[sel_q];

`ifdef MUX_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wd_rel = ~own_rel &
                  (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Hold counter: cleared on grant, saturating count
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      if (found) cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Hold counter register
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  assign wd_rel = 1'b0;
`endif

  // Next state: arbitrate in IDLE, watch for release in GRANT
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (found) begin
          state_d = ST_GRANT;
          grant_d = onehot4(idx);
          sel_d   = idx;
          ptr_d   = idx;
        end
      end
      (state_q == ST_GRANT): begin
        if (own_rel | wd_rel) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          timeout_d = wd_rel;
        end
      end
      default: ;
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd3;
      sel_q     <= 2'd0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.w_grant_4   = grant_q;
  assign bus.w_sel_2     = sel_q;
  assign bus.w_busy_1    = (state_q == ST_GRANT);
  assign bus.w_timeout_1 = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter.
// Transaction-level owner model plus directed literals.
module tb_mux_sel_arbiter;

  localparam int HOLD = 4;
`ifdef MUX_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(
    .MAX_HOLD (HOLD),
    .CNT_W    (8)
  ) dut (
    .w_clock   (clk),
    .w_reset_n (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int         m_owner = -1;
  int         m_last = 3;
  int         m_n = 0;
  int         m_c = 0;
  logic [1:0] m_sel = 2'd0;
  logic       m_to = 1'b0;

  // Owner model: who holds the port, and for how long
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 3;
      m_n     = 0;
      m_sel   = 2'd0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          m_c = (m_last + k) % 4;
          if (bus.w_req_4[m_c]) begin
            m_owner = m_c;
            m_last  = m_c;
            m_sel   = m_c[1:0];
            m_n     = 1;
            break;
          end
        end
      end else if (bus.w_done_4[m_owner] ||
                   !bus.w_req_4[m_owner]) begin
        m_owner = -1;
      end else if (WD && m_n == HOLD) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_n++;
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_grant();
    if (m_owner < 0) return 4'b0000;
    return 4'b0001 << m_owner;
  endfunction

  // Cycle compare against the model, away from the edge
  always @(negedge clk) begin
    check("m_grant", 32'(bus.w_grant_4), 32'(m_grant()));
    check("m_sel", 32'(bus.w_sel_2), 32'(m_sel));
    check("m_busy", 32'(bus.w_busy_1),
          32'(m_owner >= 0));
    check("m_to", 32'(bus.w_timeout_1), 32'(m_to));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int         n;
  int         to_cnt;
  logic [3:0] g;

  initial begin
    bus.w_req_4  = 4'b0000;
    bus.w_done_4 = 4'b0000;
    #1 rst_n = 1'b0;
    #2;
    check("rst_grant", 32'(bus.w_grant_4), 0);
    check("rst_sel", 32'(bus.w_sel_2), 0);
    check("rst_busy", 32'(bus.w_busy_1), 0);
    check("rst_to", 32'(bus.w_timeout_1), 0);
    #19 rst_n = 1'b1;

    // All request: done each tenure, sel 0,1,2,3,0
    bus.w_req_4 = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      check("rr_grant", 32'(bus.w_grant_4), 32'(g));
      check("rr_sel", 32'(bus.w_sel_2), k % 4);
      bus.w_done_4 = g;
      step();
      bus.w_done_4 = 4'b0000;
      check("rr_idle", 32'(bus.w_grant_4), 0);
      check("rr_hold_sel", 32'(bus.w_sel_2), k % 4);
      if (k == 4) bus.w_req_4 = 4'b0000;
      step();
    end

    // Owner 2; non-owner done ignored; withdraw
    bus.w_req_4 = 4'b0101;
    step();
    check("o2_grant", 32'(bus.w_grant_4), 32'h4);
    check("o2_sel", 32'(bus.w_sel_2), 2);
    bus.w_done_4 = 4'b0001;
    step();
    bus.w_done_4 = 4'b0000;
    check("o2_ign", 32'(bus.w_grant_4), 32'h4);
    step();
    check("o2_keep", 32'(bus.w_grant_4), 32'h4);
    bus.w_req_4 = 4'b0001;
    step();
    check("o2_drop", 32'(bus.w_grant_4), 0);
    check("o2_busy", 32'(bus.w_busy_1), 0);
    step();
    check("o0_grant", 32'(bus.w_grant_4), 32'h1);
    bus.w_req_4 = 4'b0000;
    step();
    step();

    // Sole requester 1 re-granted after each idle
    bus.w_req_4 = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      check("s1_grant", 32'(bus.w_grant_4), 32'h2);
      check("s1_sel", 32'(bus.w_sel_2), 1);
      bus.w_done_4 = 4'b0010;
      step();
      bus.w_done_4 = 4'b0000;
      check("s1_rel", 32'(bus.w_grant_4), 0);
      check("s1_sel_h", 32'(bus.w_sel_2), 1);
    end
    bus.w_req_4 = 4'b0000;
    step();

    // Async reset mid-grant to 3
    bus.w_req_4 = 4'b1000;
    step();
    check("r3_grant", 32'(bus.w_grant_4), 32'h8);
    check("r3_sel", 32'(bus.w_sel_2), 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(bus.w_grant_4), 0);
    check("ar_sel", 32'(bus.w_sel_2), 0);
    check("ar_busy", 32'(bus.w_busy_1), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    check("ar_regrant", 32'(bus.w_grant_4), 32'h8);
    check("ar_resel", 32'(bus.w_sel_2), 3);
    bus.w_req_4 = 4'b0000;
    step();
    step();

    // Hold requester 0 without done
    bus.w_req_4 = 4'b0011;
    step();
    check("wd_grant", 32'(bus.w_grant_4), 32'h1);
    n = 0;
    to_cnt = 0;
    while (bus.w_grant_4 != 4'b0000 && n < 120) begin
      n++;
      step();
      to_cnt += int'(bus.w_timeout_1);
    end
    check("wd_cycles", n, WD ? HOLD : 120);
    check("wd_to_drop", 32'(bus.w_timeout_1), 32'(WD));
    bus.w_req_4 = 4'b0010;
    n = 0;
    while (bus.w_grant_4 != 4'b0010 && n < 4) begin
      n++;
      step();
      to_cnt += int'(bus.w_timeout_1);
    end
    check("wd_next", 32'(bus.w_grant_4), 32'h2);
    check("wd_next_sel", 32'(bus.w_sel_2), 1);
    check("wd_to_cnt", to_cnt, WD ? 1 : 0);
    bus.w_req_4 = 4'b0000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
